reg_file_param: RTL and testbench



---
 rtl/reg_file_param.sv | 136 +++++++++++++
 tb/tb_reg_file_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parametrised multi-read / single-write register file with a
//                hardware clear sequencer, programmable reset value for one
//                register, optional same-cycle write-to-read forwarding and a
//                sticky illegal-write flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   1             rising-edge clock
//    rst   in   1             synchronous active-low reset
//    RA    in   NREAD*ADDR_W  flattened read addresses, port i at [i*ADDR_W +: ADDR_W]
//    RD    out  NREAD*DATA_W  flattened read data,      port i at [i*DATA_W +: DATA_W]
//    WA    in   ADDR_W        write address
//    WD    in   DATA_W        write data
//    WE    in   1             write enable
//    busy  out  1             high during reset and while the clear sequence runs
//    err   out  1             sticky flag: write attempted to an unimplemented index
//
//  Build option
//    REGFILE_BYPASS_EN  when defined, a read port whose address matches a legal
//                       write in the same cycle returns WD instead of the array.
// ============================================================================
module reg_file_param #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 5,
    parameter int               NUM_REGS = 32,
    parameter int               NREAD    = 2,
    parameter int               RST_IDX  = 9,
    parameter logic [DATA_W-1:0] RST_VAL = 32'h0000_0020
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] RA,
    output logic [NREAD*DATA_W-1:0] RD,
    input  logic [ADDR_W-1:0]       WA,
    input  logic [DATA_W-1:0]       WD,
    input  logic                    WE,
    output logic                    busy,
    output logic                    err
);

    // Index width that exactly spans the implemented registers.
    localparam int                c_IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0]   c_NUM_REGS   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [c_IDX_W-1:0] c_LAST_PTR  = c_IDX_W'(NUM_REGS - 1);
    localparam logic [c_IDX_W-1:0] c_RST_PTR   = c_IDX_W'(RST_IDX);
    localparam logic [c_IDX_W-1:0] c_PTR_ONE   = c_IDX_W'(1);
    // Guards against a truncated RST_IDX aliasing onto a real register.
    localparam bit                c_RST_IN_RNG = (RST_IDX >= 0) && (RST_IDX < NUM_REGS);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_clr_ptr;
    logic               r_busy;
    logic               r_err;
    logic [DATA_W-1:0]  r_mem [0:NUM_REGS-1];

    logic               w_wa_ok;
    logic [c_IDX_W-1:0] w_wa_idx;
    logic               w_wr_req;

    assign w_wa_ok  = ({1'b0, WA} < c_NUM_REGS);
    assign w_wa_idx = WA[c_IDX_W-1:0];
    // Legal write request in normal operation; also the forwarding qualifier.
    assign w_wr_req = (r_state == c_ST_READY) && WE && w_wa_ok;

    // ------------------------------------------------------------------------
    // Sequencer, array and status flags. Reset only re-arms the sequencer;
    // the array itself is initialised by the clear walk, one index per edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_mem[r_clr_ptr] <= (c_RST_IN_RNG && (r_clr_ptr == c_RST_PTR)) ? RST_VAL : '0;
                    r_clr_ptr        <= r_clr_ptr + c_PTR_ONE;
                    if (r_clr_ptr == c_LAST_PTR) begin
                        r_state <= c_ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                c_ST_READY: begin
                    if (w_wr_req) begin
                        r_mem[w_wa_idx] <= WD;
                    end else if (WE) begin
                        // WE with an out-of-range address
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_ST_CLEAR;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign err  = r_err;

    // ------------------------------------------------------------------------
    // Combinational read ports.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
        logic [ADDR_W-1:0]  w_ra;
        logic [c_IDX_W-1:0] w_ra_idx;
        logic               w_ra_ok;
        logic               w_fwd;
        logic [DATA_W-1:0]  w_rd;

        assign w_ra     = RA[gi*ADDR_W +: ADDR_W];
        assign w_ra_idx = w_ra[c_IDX_W-1:0];
        assign w_ra_ok  = ({1'b0, w_ra} < c_NUM_REGS);
`ifdef REGFILE_BYPASS_EN
        assign w_fwd    = w_wr_req && (w_ra == WA);
`else
        assign w_fwd    = 1'b0;
`endif
        assign w_rd = (r_busy || !w_ra_ok) ? '0 :
                      w_fwd                ? WD : r_mem[w_ra_idx];

        assign RD[gi*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_param
//  Description : Directed self-checking bench for reg_file_param. Drives a
//                default 32-register instance and a 16-register instance
//                (for illegal-write behaviour).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic        clk;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [9:0]  w_ra_bus;
    logic [63:0] w_rd_bus;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        w_busy, w_err;

    logic        rst16;
    logic [4:0]  ra16_0, ra16_1;
    logic [9:0]  w_ra16_bus;
    logic [63:0] w_rd16_bus;
    logic [4:0]  wa16;
    logic [31:0] wd16;
    logic        we16;
    logic        w_busy16, w_err16;

    logic [31:0] exp_mem   [0:31];
    logic [31:0] exp_mem16 [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    assign w_ra_bus   = {ra1, ra0};
    assign w_ra16_bus = {ra16_1, ra16_0};

    reg_file_param dut (
        .clk  (clk),
        .rst  (rst),
        .RA   (w_ra_bus),
        .RD   (w_rd_bus),
        .WA   (wa),
        .WD   (wd),
        .WE   (we),
        .busy (w_busy),
        .err  (w_err)
    );

    reg_file_param #(.NUM_REGS(16)) dut16 (
        .clk  (clk),
        .rst  (rst16),
        .RA   (w_ra16_bus),
        .RD   (w_rd16_bus),
        .WA   (wa16),
        .WD   (wd16),
        .WE   (we16),
        .busy (w_busy16),
        .err  (w_err16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int r = 0; r < 32; r++) exp_mem[r] = 32'h0;
        exp_mem[9] = 32'h0000_0020;
    endtask

    // Sweep all registers through both read ports (port 1 in reverse order).
    task automatic compare_all(input string pfx);
        for (int r = 0; r < 32; r++) begin
            ra0 = 5'(r);
            ra1 = 5'(31 - r);
            #1;
            check($sformatf("%s_rd0_r%0d", pfx, r), w_rd_bus[31:0], exp_mem[r]);
            check($sformatf("%s_rd1_r%0d", pfx, 31 - r), w_rd_bus[63:32], exp_mem[31 - r]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0;
        rst16 = 1'b0; we16 = 1'b0; wa16 = '0; wd16 = '0; ra16_0 = '0; ra16_1 = '0;

        // ---------------- reset and first clear ----------------
        repeat (3) tick();
        ra0 = 5'd9;
        #1;
        check("reset_busy", w_busy, 1);
        check("reset_err", w_err, 0);
        check("reset_rd0_zero", w_rd_bus[31:0], 0);

        // Release reset while attempting a write to register 3 during clear.
        rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h1;
        repeat (31) tick();
        check("clear_busy_31", w_busy, 1);
        check("clear_rd_zero_busy", w_rd_bus[31:0], 0);
        tick();
        check("clear_busy_32", w_busy, 0);
        check("busy_write_err", w_err, 0);
        we = 1'b0;

        reset_model();
        compare_all("clr1");

        // ---------------- single write ----------------
        tick();
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; ra0 = 5'd5; ra1 = 5'd5;
        #1;
        check("wr5_rd0", w_rd_bus[31:0], 32'hDEAD_BEEF);
        check("wr5_rd1", w_rd_bus[63:32], 32'hDEAD_BEEF);
        exp_mem[5] = 32'hDEAD_BEEF;
        compare_all("wr5");

        // ---------------- same-cycle write/read ----------------
        tick();
        ra0 = 5'd7; ra1 = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd0_same", w_rd_bus[31:0], 32'h1234_5678);
        check("byp_rd1_same", w_rd_bus[63:32], 32'h1234_5678);
`else
        check("byp_rd0_same", w_rd_bus[31:0], 32'h0);
        check("byp_rd1_same", w_rd_bus[63:32], 32'h0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("byp_rd0_next", w_rd_bus[31:0], 32'h1234_5678);
        exp_mem[7] = 32'h1234_5678;

        // ---------------- fill, then reset mid-clear ----------------
        for (int r = 0; r < 32; r++) begin
            we = 1'b1; wa = 5'(r); wd = 32'hFFFF_FFFF;
            tick();
        end
        we = 1'b0;
        for (int r = 0; r < 32; r++) exp_mem[r] = 32'hFFFF_FFFF;
        compare_all("fill");

        rst = 1'b0;
        tick();
        check("restart_busy_rst", w_busy, 1);
        rst = 1'b1;
        repeat (10) tick();
        check("restart_busy_step10", w_busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("restart_busy_pulse", w_busy, 1);
        repeat (31) tick();
        check("restart_busy_31", w_busy, 1);
        tick();
        check("restart_busy_32", w_busy, 0);
        reset_model();
        compare_all("restart");

        // ---------------- 16-register instance: illegal write ----------------
        rst16 = 1'b1;
        repeat (15) tick();
        check("r16_busy_15", w_busy16, 1);
        tick();
        check("r16_busy_16", w_busy16, 0);
        for (int r = 0; r < 16; r++) exp_mem16[r] = 32'h0;
        exp_mem16[9] = 32'h0000_0020;

        we16 = 1'b1; wa16 = 5'd2; wd16 = 32'hAAAA_5555;
        tick();
        exp_mem16[2] = 32'hAAAA_5555;
        wa16 = 5'd20; wd16 = 32'hCAFE_F00D;
        #1;
        check("r16_err_before", w_err16, 0);
        tick();
        we16 = 1'b0;
        check("r16_err_set", w_err16, 1);
        tick();
        check("r16_err_sticky", w_err16, 1);
        ra16_0 = 5'd20; ra16_1 = 5'd31;
        #1;
        check("r16_rd_oob20", w_rd16_bus[31:0], 0);
        check("r16_rd_oob31", w_rd16_bus[63:32], 0);
        for (int r = 0; r < 16; r++) begin
            ra16_0 = 5'(r);
            #1;
            check($sformatf("r16_rd_r%0d", r), w_rd16_bus[31:0], exp_mem16[r]);
        end
        tick();
        rst16 = 1'b0;
        tick();
        check("r16_err_cleared", w_err16, 0);
        check("r16_busy_rst", w_busy16, 1);
        rst16 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
